tpu_move_tx: RTL and testbench
==============================

# tpu_move_tx

Link-side transmitter that sends the TPU's chosen move to the host over the byte-wide, source-synchronous select/clock/data link (`clk_out`, `sel_out`, `data_out`). It is the outbound counterpart of the TPU's inbound `clk_in`/`sel_in`/`data_in` port. The core hands it a move word over a valid/ready handshake. The block slices the word into bytes, MSB byte first, and frames them under `sel_out` with a divided link clock.

## Interface
Parameters:
- `DATA_WIDTH`, 8: link byte width.
- `NUM_BYTES`, 2: bytes per move; move word is `DATA_WIDTH*NUM_BYTES` bits (16 by default). Must be ≥1.
- `CLK_DIV`, 2: system-clock cycles per link-clock half period. Must be ≥1.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `nrst` in 1: reset, asynchronous and active-low.
- `move_data` in `DATA_WIDTH*NUM_BYTES`: move to send (e.g. `optimal_move`).
- `move_valid` in 1: `move_data` is valid.
- `move_ready` out 1: block can accept a move.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse when a frame completes.
- `clk_out` out 1: link clock. The receiver samples `data_out` on the rising edge.
- `sel_out` out 1: frame select, active-high.
- `data_out` out `DATA_WIDTH`: link data.

## Operation
- States: IDLE, LOW, HIGH, TAIL.
  - Phase counter: `$clog2(CLK_DIV)` bits, minimum 1.
  - Byte counter: `$clog2(NUM_BYTES)` bits, minimum 1.
- IDLE:
  - `move_ready`=1, `busy`=0, `sel_out`=0, `clk_out`=0, `data_out`=0.
  - On `move_valid && move_ready`: latch `move_data` into the shift register, clear both counters, go to LOW.
- LOW:
  - `sel_out`=1, `clk_out`=0, `data_out` = current byte (bits [MSB -: DATA_WIDTH] of the shift register).
  - After `CLK_DIV` cycles, go to HIGH.
- HIGH:
  - `clk_out`=1, `data_out` held stable.
  - After `CLK_DIV` cycles:
    - If the byte counter = `NUM_BYTES-1`, go to TAIL.
    - Otherwise, shift the register left by `DATA_WIDTH`, increment the byte counter, go to LOW.
- TAIL:
  - `clk_out`=0, `sel_out`=1, last byte held for `CLK_DIV` cycles.
  - Then go to IDLE, assert `done` for exactly that first IDLE cycle, and drive `sel_out`/`data_out` to 0.
- Handshake:
  - `move_ready` = (state == IDLE), including the `done` cycle.
  - `move_valid` and `move_data` are ignored outside IDLE. `move_data` changing mid-frame has no effect on the frame.
- `busy` = state ≠ IDLE.
- `clk_out`, `sel_out`, `data_out` and `done` are registered; there is no combinational path from inputs to link outputs.
- Reset:
  - Asserting `nrst` at any time forces IDLE immediately, with no clock needed.
  - All outputs go to 0 except `move_ready`, which goes to 1.
  - A frame cut off by reset is lost. The receiver sees `sel_out` drop and discards the partial frame.

## Timing
- Handshake accepted at edge T:
  - `sel_out`=1 and byte 0 appear from cycle T+1.
  - Rising `clk_out` for byte k occurs at T+1+(2k+1)·`CLK_DIV`.
  - Data is stable `CLK_DIV` cycles before and `CLK_DIV` cycles after each rising edge.
- `sel_out` is high for exactly (2·`NUM_BYTES`+1)·`CLK_DIV` cycles: 10 with the defaults.
- `done` is high in cycle T+1+(2·`NUM_BYTES`+1)·`CLK_DIV`: T+11 with the defaults. `sel_out` is 0 in that cycle.
- Back-to-back: a move accepted in the `done` cycle gives exactly one cycle of `sel_out`=0 between frames. Minimum accept-to-accept spacing is (2·`NUM_BYTES`+1)·`CLK_DIV`+1 cycles.
- `clk_out` is 0 whenever `sel_out` is 0, and is 0 at both frame edges.
- `CLK_DIV`=1 gives single-cycle phases. `NUM_BYTES`=1 goes LOW→HIGH→TAIL.

## Test plan
- Defaults, `move_data`=16'hA55A, one-cycle valid:
  - `sel_out` high 10 cycles.
  - Rising `clk_out` at T+3 and T+7 sampling 8'hA5 then 8'h5A.
  - `done` at T+11.
  - `move_ready`=0 during T+1..T+10.
- Valid held continuously with 16'h1234 then 16'hBEEF:
  - Second accept occurs in the `done` cycle.
  - One-cycle `sel_out` gap between frames.
  - Bytes received: 12,34,BE,EF.
- Change `move_data` and pulse `move_valid` mid-frame:
  - Transmitted bytes unchanged.
  - No extra frame.
  - `move_ready` stays 0 until `done`.
- `CLK_DIV`=1, `NUM_BYTES`=1, data 8'hC3:
  - `sel_out` high 3 cycles.
  - Single rising `clk_out` at T+2 with `data_out`=C3.
  - `done` at T+4.
- Drop `nrst` asynchronously during the second HIGH phase:
  - `sel_out`, `clk_out`, `data_out`, `done`, `busy` go to 0 without a clock edge; `move_ready`=1.
  - After release, a new move 16'h0F0F transmits correctly.
- `move_valid` held low for 50 cycles after reset:
  - Outputs stay idle (all 0, `move_ready`=1).
  - No `clk_out` toggles.

Source files
------------

// File: rtl/tpu_move_tx.sv
// Outbound move transmitter: slices a move word MSB byte first onto the
// select/clock/data link, with each link half-period lasting CLK_DIV system clocks.
module tpu_move_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BYTES  = 2,
  parameter int CLK_DIV    = 2
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [DATA_WIDTH*NUM_BYTES-1:0]  move_data,
  input  logic                             move_valid,
  output logic                             move_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             clk_out,
  output logic                             sel_out,
  output logic [DATA_WIDTH-1:0]            data_out
);

  localparam int MW = DATA_WIDTH * NUM_BYTES;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BY_LAST = BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_TAIL} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [MW-1:0]         shreg_q, shreg_d;
  logic                  done_q, done_d;
  logic                  clk_out_q, clk_out_d;
  logic                  sel_out_q, sel_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic          phase_end;
  logic [MW-1:0] shreg_next;

  assign phase_end  = (phase_q == PH_LAST);
  assign shreg_next = shreg_q << DATA_WIDTH;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    byte_d     = byte_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
    clk_out_d  = clk_out_q;
    sel_out_d  = sel_out_q;
    data_out_d = data_out_q;
    case (state_q)
      S_IDLE: begin
        if (move_valid) begin
          state_d    = S_LOW;
          shreg_d    = move_data;
          phase_d    = '0;
          byte_d     = '0;
          sel_out_d  = 1'b1;
          clk_out_d  = 1'b0;
          data_out_d = move_data[MW-1 -: DATA_WIDTH];
        end
      end
      S_LOW: begin
        if (phase_end) begin
          state_d   = S_HIGH;
          phase_d   = '0;
          clk_out_d = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          phase_d   = '0;
          clk_out_d = 1'b0;
          if (byte_q == BY_LAST) begin
            state_d = S_TAIL;
          end else begin
            // Next byte goes out together with the falling link clock.
            state_d    = S_LOW;
            byte_d     = byte_q + BW'(1);
            shreg_d    = shreg_next;
            data_out_d = shreg_next[MW-1 -: DATA_WIDTH];
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_TAIL: begin
        if (phase_end) begin
          state_d    = S_IDLE;
          phase_d    = '0;
          done_d     = 1'b1;
          sel_out_d  = 1'b0;
          data_out_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      done_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      sel_out_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      byte_q     <= byte_d;
      shreg_q    <= shreg_d;
      done_q     <= done_d;
      clk_out_q  <= clk_out_d;
      sel_out_q  <= sel_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign move_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign clk_out    = clk_out_q;
  assign sel_out    = sel_out_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_tpu_move_tx.sv
// Bench for tpu_move_tx: frame waveforms predicted from the link timing rules,
// plus a receiver model that captures data_out on each rising clk_out.
module tb_tpu_move_tx;
  localparam int NB = 2;
  localparam int CD = 2;
  localparam int FL = (2 * NB + 1) * CD;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] d0 = '0;
  logic        v0 = 1'b0;
  logic        r0, b0, dn0, co0, so0;
  logic [7:0]  do0;
  logic [7:0]  d1 = '0;
  logic        v1 = 1'b0;
  logic        r1, b1, dn1, co1, so1;
  logic [7:0]  do1;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] rx0[$];
  logic [7:0] rx1[$];
  logic pco0 = 1'b0;
  logic pco1 = 1'b0;

  tpu_move_tx #(.DATA_WIDTH(8), .NUM_BYTES(NB), .CLK_DIV(CD)) dut0 (
    .clk(clk), .nrst(nrst), .move_data(d0), .move_valid(v0), .move_ready(r0),
    .busy(b0), .done(dn0), .clk_out(co0), .sel_out(so0), .data_out(do0));

  tpu_move_tx #(.DATA_WIDTH(8), .NUM_BYTES(1), .CLK_DIV(1)) dut1 (
    .clk(clk), .nrst(nrst), .move_data(d1), .move_valid(v1), .move_ready(r1),
    .busy(b1), .done(dn1), .clk_out(co1), .sel_out(so1), .data_out(do1));

  always #5 clk = ~clk;

  // Receiver model: latch data on each rising link clock.
  always @(posedge clk) begin
    if (co0 && !pco0) rx0.push_back(do0);
    if (co1 && !pco1) rx1.push_back(do1);
    pco0 <= co0;
    pco1 <= co1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [15:0] w, input int k);
    return w[8*(NB-1-k) +: 8];
  endfunction

  // Call at cycle T+1 after an accept; returns in the done cycle.
  task automatic expect_frame(input logic [15:0] w, input bit noise, input bit hold_valid);
    int p, k;
    logic ec;
    logic [7:0] eb;
    rx0.delete();
    for (int n = 1; n <= FL; n++) begin
      p  = (n - 1) / CD;
      k  = (p / 2 < NB) ? p / 2 : NB - 1;
      ec = (p % 2 == 1);
      eb = byte_of(w, k);
      nvec++; if (so0 !== 1'b1) begin nerr++; $display("FAIL sel n=%0d got %b exp 1", n, so0); end
      nvec++; if (co0 !== ec) begin nerr++; $display("FAIL clk_out n=%0d got %b exp %b", n, co0, ec); end
      nvec++; if (do0 !== eb) begin nerr++; $display("FAIL data n=%0d got %h exp %h", n, do0, eb); end
      nvec++; if ({r0, b0, dn0} !== 3'b010) begin
        nerr++; $display("FAIL hs n=%0d ready/busy/done got %b exp 010", n, {r0, b0, dn0});
      end
      if (noise) begin d0 = 16'($urandom); v0 = 1'($urandom_range(0, 1)); end
      if (n == FL && !hold_valid) v0 = 1'b0;
      cyc();
    end
    nvec++; if ({dn0, so0, co0, r0, b0} !== 5'b10010) begin
      nerr++; $display("FAIL done_cycle done/sel/clk/ready/busy got %b exp 10010", {dn0, so0, co0, r0, b0});
    end
    nvec++; if (do0 !== 8'h00) begin nerr++; $display("FAIL done_data got %h exp 00", do0); end
    nvec++;
    if (rx0.size() != NB) begin
      nerr++; $display("FAIL rx_count got %0d exp %0d", rx0.size(), NB);
    end else begin
      for (int j = 0; j < NB; j++) begin
        nvec++; if (rx0[j] !== byte_of(w, j)) begin
          nerr++; $display("FAIL rx_byte%0d got %h exp %h", j, rx0[j], byte_of(w, j));
        end
      end
    end
  endtask

  task automatic start0(input logic [15:0] w);
    nvec++; if (r0 !== 1'b1) begin nerr++; $display("FAIL pre_accept_ready got %b exp 1", r0); end
    d0 = w; v0 = 1'b1;
    cyc();
    v0 = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    cyc(); cyc();
    nvec++; if ({r0, b0, dn0, co0, so0, do0} !== {5'b10000, 8'h00}) begin
      nerr++; $display("FAIL reset0 got %b exp %b", {r0, b0, dn0, co0, so0, do0}, {5'b10000, 8'h00});
    end
    nvec++; if ({r1, b1, dn1, co1, so1, do1} !== {5'b10000, 8'h00}) begin
      nerr++; $display("FAIL reset1 got %b exp %b", {r1, b1, dn1, co1, so1, do1}, {5'b10000, 8'h00});
    end
    nrst = 1'b1;
    cyc();
  endtask

  task automatic test_idle();
    int toggles = 0;
    logic prev = co0;
    v0 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (co0 !== prev) toggles++;
      prev = co0;
      nvec++; if ({r0, b0, dn0, co0, so0, do0} !== {5'b10000, 8'h00}) begin
        nerr++; $display("FAIL idle i=%0d got %b exp %b", i, {r0, b0, dn0, co0, so0, do0}, {5'b10000, 8'h00});
      end
    end
    nvec++; if (toggles != 0) begin nerr++; $display("FAIL idle_toggles got %0d exp 0", toggles); end
  endtask

  task automatic test_single();
    start0(16'hA55A);
    expect_frame(16'hA55A, 1'b0, 1'b0);
    cyc();
    nvec++; if ({dn0, so0, r0} !== 3'b001) begin
      nerr++; $display("FAIL single_after done/sel/ready got %b exp 001", {dn0, so0, r0});
    end
  endtask

  task automatic test_back_to_back();
    d0 = 16'h1234; v0 = 1'b1;
    cyc();
    d0 = 16'hBEEF;
    expect_frame(16'h1234, 1'b0, 1'b1);
    cyc();
    v0 = 1'b0;
    expect_frame(16'hBEEF, 1'b0, 1'b0);
    cyc();
    nvec++; if ({so0, r0} !== 2'b01) begin
      nerr++; $display("FAIL b2b_end sel/ready got %b exp 01", {so0, r0});
    end
  endtask

  task automatic test_midframe();
    start0(16'h3C96);
    expect_frame(16'h3C96, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      nvec++; if ({so0, co0, b0, r0, dn0} !== 5'b00010) begin
        nerr++; $display("FAIL no_extra_frame i=%0d got %b exp 00010", i, {so0, co0, b0, r0, dn0});
      end
    end
  endtask

  task automatic test_small();
    logic [5:0] exp_v [1:4];
    exp_v[1] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // sel clk data_ok ready done busy
    exp_v[2] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_v[3] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_v[4] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    d1 = 8'hC3; v1 = 1'b1;
    cyc();
    v1 = 1'b0;
    d1 = 8'h00;
    rx1.delete();
    for (int n = 1; n <= 4; n++) begin
      logic dok;
      dok = (n <= 3) ? (do1 === 8'hC3) : (do1 === 8'h00);
      nvec++; if ({so1, co1, dok, r1, dn1, b1} !== exp_v[n]) begin
        nerr++; $display("FAIL small n=%0d got %b exp %b data %h", n, {so1, co1, dok, r1, dn1, b1}, exp_v[n], do1);
      end
      cyc();
    end
    nvec++; if (rx1.size() != 1 || rx1[0] !== 8'hC3) begin
      nerr++; $display("FAIL small_rx got n=%0d exp one byte C3", rx1.size());
    end
  endtask

  task automatic test_async_reset();
    start0(16'($urandom));
    for (int n = 1; n < 7; n++) cyc();
    nvec++; if (co0 !== 1'b1) begin nerr++; $display("FAIL pre_reset_high got %b exp 1", co0); end
    #2;
    nrst = 1'b0;
    #1;
    nvec++; if ({so0, co0, dn0, b0, r0, do0} !== {5'b00001, 8'h00}) begin
      nerr++; $display("FAIL async_reset got %b exp %b", {so0, co0, dn0, b0, r0, do0}, {5'b00001, 8'h00});
    end
    cyc(); cyc();
    nrst = 1'b1;
    cyc();
    start0(16'h0F0F);
    expect_frame(16'h0F0F, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int f = 0; f < 20; f++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        cyc();
        nvec++; if ({so0, r0} !== 2'b01) begin
          nerr++; $display("FAIL rand_gap f=%0d got %b exp 01", f, {so0, r0});
        end
      end
      w = 16'($urandom);
      start0(w);
      expect_frame(w, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    cyc();
    test_back_to_back();
    test_midframe();
    test_small();
    test_async_reset();
    test_random();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
